fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_skid.sv | 57 +++++
 rtl/fifo_reader.sv | 80 ++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared widths, buffer depth and FSM state encoding for the fifo_reader block.
package fifo_reader_pkg;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 16;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer: head drives the stream, tail absorbs a capture while the head stalls.
module fifo_reader_skid
  import fifo_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [OCC_W-1:0]  occ
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              pop;

  assign m_valid = (occ != '0);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ != FULL) begin
            if (occ == '0) head <= din;
            else           tail <= din;
            occ <= occ + 1'b1;
          end
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 1'b1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new byte lands behind whatever remains.
          if (occ == FULL) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Drains an upstream FIFO into a valid/ready byte stream with read-issue flow control.
// Define FIFO_READER_PARITY_EN to add the m_parity output (XOR of m_data).
module fifo_reader
  import fifo_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [CNT_W-1:0]  pop_count
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic              m_parity
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic [OCC_W:0]   committed;

  assign pop = m_valid & m_ready;

  // The byte leaving this cycle is not counted, so a free-flowing stream reads every cycle.
  assign committed = {1'b0, occ} - {{OCC_W{1'b0}}, pop} + {{OCC_W{1'b0}}, inflight};

  assign fifo_rd = ~rst & en & ~fifo_empty & (state == ACTIVE)
                 & (committed < (OCC_W + 1)'(BUF_DEPTH));

  assign busy = inflight | (occ != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      pop_count <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd;
      if (fifo_rd) pop_count <= pop_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ACTIVE;
      ACTIVE:  if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                           state_nxt = ACTIVE;
        else if (!inflight && occ == '0)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  fifo_reader_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .push    (inflight),
    .din     (fifo_dout),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .occ     (occ)
  );

`ifdef FIFO_READER_PARITY_EN
  assign m_parity = ^m_data;
`endif

endmodule
